fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
- Fetch-stage sequencer that owns the PC register's next-value and stall inputs.
- Issues one instruction-memory request at a time for the current PC and returns the fetched word to the IF/ID boundary.
- Holds the word while decode is stalled, and applies decode-stage redirects (branch/jump), discarding any fetch already in flight.
- Sits between the PC register, the instruction-memory handshake and the hazard unit.

Parameters:
RESET_PC, 32'h0000_3000, value driven on FC_npc_F_o during and immediately after reset.
TIMEOUT, 16, WAIT-state cycle count after which FC_timeout_F_o sets.

Ports:
FC_clk_F_i  in  1  clock, rising edge.
FC_reset_F_i  in  1  asynchronous, active-low reset.
FC_pc_F_i  in  32  current PC from the PC register.
FC_stall_D_i  in  1  hazard-unit stall: decode cannot accept an instruction.
FC_redir_D_i  in  1  redirect request from decode (branch taken / jump).
FC_redir_tgt_D_i  in  32  redirect target.
FC_imem_req_F_o  out  1  instruction-memory request.
FC_imem_addr_F_o  out  32  request address; equals FC_pc_F_i.
FC_imem_gnt_F_i  in  1  memory accepted the address this cycle.
FC_imem_rvalid_F_i  in  1  read data valid.
FC_imem_rdata_F_i  in  32  read data.
FC_npc_F_o  out  32  next PC to the PC register.
FC_pcstall_F_o  out  1  stall to the PC register (1 = hold).
FC_instr_F_o  out  32  instruction to IF/ID.
FC_instr_vld_F_o  out  1  FC_instr_F_o valid.
FC_timeout_F_o  out  1  sticky memory-timeout flag.

Behaviour:
- Reset asserted (asynchronous):
  - State goes to IDLE; kill_pending, hold register, timeout counter and timeout flag clear.
  - Outputs: imem_req=0, instr_vld=0, instr=0, pcstall=1, npc=RESET_PC, timeout=0.
  - Reset asserted mid-transaction abandons the transaction; a late rvalid in IDLE is ignored.
- States and transitions:
  - IDLE: one cycle after reset release, then REQ.
  - REQ: imem_req=1, addr=FC_pc_F_i. On gnt go to WAIT.
  - WAIT: req=0; the timeout counter increments each cycle.
  - HOLD: instr_vld=1 and instr = hold register, held stable until accepted.
- Advance cycle: pcstall=0 and npc=FC_pc_F_i+4 (mod 2^32, wrap to 0). Advance occurs only when an instruction is accepted:
  - in WAIT: rvalid=1, kill_pending=0 and stall_D=0. instr/instr_vld pass through combinationally (zero added latency), then go to REQ.
  - in HOLD: stall_D=0, then go to REQ.
- Stall during delivery: WAIT with rvalid=1, kill_pending=0 and stall_D=1 captures rdata into the hold register and goes to HOLD; pcstall stays 1.
- pcstall=1 in every other cycle, except redirect cycles.
- Redirect (FC_redir_D_i=1 and FC_stall_D_i=0):
  - Common effect: pcstall=0, npc={tgt[31:2],2'b00}. Redirect takes priority over sequential advance and instr_vld is forced 0 that cycle.
  - Redirect with stall_D=1 is ignored.
  - IDLE: ignored.
  - REQ without gnt: next state REQ; the new PC is presented next cycle.
  - REQ with gnt in the same cycle: next state WAIT, kill_pending set.
  - WAIT without rvalid: kill_pending set, stay in WAIT.
  - WAIT with rvalid in the same cycle: data discarded, go to REQ.
  - HOLD: held instruction discarded, go to REQ.
- Killed response: WAIT with rvalid=1 and kill_pending=1 discards data (instr_vld=0), clears kill_pending, goes to REQ; no PC change.
- Delay-slot ordering is the decoder's responsibility; redirect is asserted only after the slot instruction has been accepted.
- Timeout counter clears on leaving WAIT. When it reaches TIMEOUT, FC_timeout_F_o sets and stays 1 until reset. The FSM remains in WAIT; no retry.
- At most one outstanding request. rvalid outside WAIT is ignored.

Decomposition:
- Shared package fetch_pkg: state encoding (IDLE, REQ, WAIT, HOLD), RESET_PC default, word-align mask, PC increment constant 4.
- Sub-module fetch_hold_buf: 32-bit hold register plus valid, with load/clear; async active-low reset.
- FSM, redirect/kill logic and timeout counter live in fetch_ctrl.

Test Plan:
1. Reset, then release; PC reg at 0x3000; gnt=1 in REQ; rvalid one cycle later with 0x2402_0001, stall_D=0 -> in that cycle instr_vld=1, instr=0x2402_0001, pcstall=0, npc=0x3004.
2. rvalid arrives with stall_D=1 for 3 cycles, then stall_D=0 -> HOLD with instr_vld=1 and the same instr for 3 cycles, pcstall=1; on release pcstall=0 for one cycle, npc=PC+4.
3. In WAIT with no rvalid, redirect to 0x3102 -> that cycle npc=0x3100, pcstall=0; the next rvalid is discarded (instr_vld=0); then REQ with addr=0x3100.
4. Redirect in the same cycle as rvalid (stall_D=0) -> npc=target, instr_vld=0, next state REQ; no kill of the following fetch.
5. PC=0xFFFF_FFFC, instruction accepted -> npc=0x0000_0000.
6. gnt given and rvalid withheld for 16 cycles -> timeout=1 and stays 1 after a later rvalid; reset asserted mid-WAIT -> all outputs return to reset values immediately (asynchronously).

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch-stage sequencer.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
    localparam int          TIMEOUT_DEF  = 16;
    localparam logic [31:0] ALIGN_MASK   = 32'hFFFF_FFFC;
    localparam logic [31:0] PC_INC       = 32'd4;

    // Force a redirect target onto a word boundary.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & ALIGN_MASK;
    endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// Holds a fetched word while decode is stalled.
module fetch_hold_buf
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_load,
    input  logic        i_clear,
    input  logic [31:0] i_data,
    output logic [31:0] o_data,
    output logic        o_vld
);

    logic [31:0] r_data;
    logic        r_vld;

    // Load takes priority; clear drops both the word and its valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
            r_vld  <= 1'b0;
        end else if (i_load) begin
            r_data <= i_data;
            r_vld  <= 1'b1;
        end else if (i_clear) begin
            r_data <= '0;
            r_vld  <= 1'b0;
        end
    end

    assign o_data = r_data;
    assign o_vld  = r_vld;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: one outstanding imem request, hold on decode
// stall, redirect with kill of an in-flight fetch, sticky timeout.
//
// state | meaning
// IDLE  | one cycle after reset release, npc = RESET_PC
// REQ   | request driven for current PC, waiting for grant
// WAIT  | granted, waiting for rvalid; timeout counter runs
// HOLD  | word captured during stall, presented until accepted
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          TIMEOUT  = TIMEOUT_DEF
) (
    input  logic        FC_clk_F_i,
    input  logic        FC_reset_F_i,
    input  logic [31:0] FC_pc_F_i,
    input  logic        FC_stall_D_i,
    input  logic        FC_redir_D_i,
    input  logic [31:0] FC_redir_tgt_D_i,
    output logic        FC_imem_req_F_o,
    output logic [31:0] FC_imem_addr_F_o,
    input  logic        FC_imem_gnt_F_i,
    input  logic        FC_imem_rvalid_F_i,
    input  logic [31:0] FC_imem_rdata_F_i,
    output logic [31:0] FC_npc_F_o,
    output logic        FC_pcstall_F_o,
    output logic [31:0] FC_instr_F_o,
    output logic        FC_instr_vld_F_o,
    output logic        FC_timeout_F_o
);

    localparam int          CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMO_MAX  = CW'(TIMEOUT);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;
    logic         r_kill;
    logic         w_kill_nxt;
    logic [CW-1:0] r_tmo_cnt;
    logic         r_timeout;

    logic         w_redir;
    logic [31:0]  w_redir_pc;
    logic [31:0]  w_seq_pc;
    logic         w_req;
    logic         w_pcstall;
    logic [31:0]  w_npc;
    logic         w_vld;
    logic [31:0]  w_instr;
    logic         w_hold_load;
    logic         w_hold_clear;
    logic [31:0]  w_hold_data;
    logic         w_hold_vld;

    // A redirect while decode is stalled is not yet real; ignore it.
    assign w_redir    = FC_redir_D_i & ~FC_stall_D_i;
    assign w_redir_pc = align_word(FC_redir_tgt_D_i);
    assign w_seq_pc   = FC_pc_F_i + PC_INC;

    fetch_hold_buf u_hold (
        .clk     (FC_clk_F_i),
        .rst_n   (FC_reset_F_i),
        .i_load  (w_hold_load),
        .i_clear (w_hold_clear),
        .i_data  (FC_imem_rdata_F_i),
        .o_data  (w_hold_data),
        .o_vld   (w_hold_vld)
    );

    // Next-state and outputs; delivery in WAIT is combinational so an
    // accepted word reaches IF/ID with no added latency.
    always_comb begin
        w_state_nxt  = r_state;
        w_kill_nxt   = r_kill;
        w_req        = 1'b0;
        w_pcstall    = 1'b1;
        w_npc        = FC_pc_F_i;
        w_vld        = 1'b0;
        w_instr      = '0;
        w_hold_load  = 1'b0;
        w_hold_clear = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_npc       = RESET_PC;
                w_state_nxt = ST_REQ;
            end
            ST_REQ: begin
                w_req = 1'b1;
                if (w_redir) begin
                    w_pcstall = 1'b0;
                    w_npc     = w_redir_pc;
                    if (FC_imem_gnt_F_i) begin
                        w_state_nxt = ST_WAIT;
                        w_kill_nxt  = 1'b1;
                    end
                end else if (FC_imem_gnt_F_i) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (FC_imem_rvalid_F_i) begin
                    w_state_nxt = ST_REQ;
                    w_kill_nxt  = 1'b0;
                    if (w_redir) begin
                        w_pcstall = 1'b0;
                        w_npc     = w_redir_pc;
                    end else if (!r_kill) begin
                        if (!FC_stall_D_i) begin
                            w_vld     = 1'b1;
                            w_instr   = FC_imem_rdata_F_i;
                            w_pcstall = 1'b0;
                            w_npc     = w_seq_pc;
                        end else begin
                            w_hold_load = 1'b1;
                            w_state_nxt = ST_HOLD;
                        end
                    end
                end else if (w_redir) begin
                    w_pcstall  = 1'b0;
                    w_npc      = w_redir_pc;
                    w_kill_nxt = 1'b1;
                end
            end
            ST_HOLD: begin
                w_vld   = w_hold_vld;
                w_instr = w_hold_data;
                if (w_redir) begin
                    w_vld        = 1'b0;
                    w_instr      = '0;
                    w_pcstall    = 1'b0;
                    w_npc        = w_redir_pc;
                    w_hold_clear = 1'b1;
                    w_state_nxt  = ST_REQ;
                end else if (!FC_stall_D_i) begin
                    w_pcstall    = 1'b0;
                    w_npc        = w_seq_pc;
                    w_hold_clear = 1'b1;
                    w_state_nxt  = ST_REQ;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State, kill flag and timeout counter; counter clears on leaving WAIT.
    always_ff @(posedge FC_clk_F_i or negedge FC_reset_F_i) begin
        if (!FC_reset_F_i) begin
            r_state   <= ST_IDLE;
            r_kill    <= 1'b0;
            r_tmo_cnt <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_kill  <= w_kill_nxt;
            if (r_state == ST_WAIT && w_state_nxt == ST_WAIT) begin
                if (r_tmo_cnt != TMO_MAX) begin
                    r_tmo_cnt <= r_tmo_cnt + 1'b1;
                end
                if (r_tmo_cnt == TMO_LAST) begin
                    r_timeout <= 1'b1;
                end
            end else begin
                r_tmo_cnt <= '0;
            end
        end
    end

    assign FC_imem_req_F_o  = w_req;
    assign FC_imem_addr_F_o = FC_pc_F_i;
    assign FC_npc_F_o       = w_npc;
    assign FC_pcstall_F_o   = w_pcstall;
    assign FC_instr_F_o     = w_instr;
    assign FC_instr_vld_F_o = w_vld;
    assign FC_timeout_F_o   = r_timeout;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc;
    logic        stall, redir, gnt, rvalid;
    logic [31:0] tgt, rdata;
    logic        req, pcstall, vld, tmo;
    logic [31:0] addr, npc, instr;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fetch_ctrl dut (
        .FC_clk_F_i         (clk),
        .FC_reset_F_i       (rst_n),
        .FC_pc_F_i          (pc),
        .FC_stall_D_i       (stall),
        .FC_redir_D_i       (redir),
        .FC_redir_tgt_D_i   (tgt),
        .FC_imem_req_F_o    (req),
        .FC_imem_addr_F_o   (addr),
        .FC_imem_gnt_F_i    (gnt),
        .FC_imem_rvalid_F_i (rvalid),
        .FC_imem_rdata_F_i  (rdata),
        .FC_npc_F_o         (npc),
        .FC_pcstall_F_o     (pcstall),
        .FC_instr_F_o       (instr),
        .FC_instr_vld_F_o   (vld),
        .FC_timeout_F_o     (tmo)
    );

    task automatic nx();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stall = 0; redir = 0; gnt = 0; rvalid = 0;
        tgt = '0; rdata = '0; pc = 32'h0000_3000;
        #3;
        n_chk++; if (req !== 1'b0) begin n_fail++; $display("FAIL rst_req got %b exp 0", req); end
        n_chk++; if (vld !== 1'b0) begin n_fail++; $display("FAIL rst_vld got %b exp 0", vld); end
        n_chk++; if (instr !== 32'h0) begin n_fail++; $display("FAIL rst_instr got %h exp 0", instr); end
        n_chk++; if (pcstall !== 1'b1) begin n_fail++; $display("FAIL rst_pcstall got %b exp 1", pcstall); end
        n_chk++; if (npc !== 32'h0000_3000) begin n_fail++; $display("FAIL rst_npc got %h exp 00003000", npc); end
        n_chk++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL rst_tmo got %b exp 0", tmo); end
        nx(); nx();
        rst_n = 1'b1;
        smp();
        n_chk++; if (pcstall !== 1'b1) begin n_fail++; $display("FAIL idle_pcstall got %b exp 1", pcstall); end
        n_chk++; if (npc !== 32'h0000_3000) begin n_fail++; $display("FAIL idle_npc got %h exp 00003000", npc); end
        n_chk++; if (req !== 1'b0) begin n_fail++; $display("FAIL idle_req got %b exp 0", req); end
        nx();
    endtask

    task automatic test_basic_fetch();
        pc = 32'h0000_3000; gnt = 1;
        smp();
        n_chk++; if (req !== 1'b1) begin n_fail++; $display("FAIL basic_req got %b exp 1", req); end
        n_chk++; if (addr !== 32'h0000_3000) begin n_fail++; $display("FAIL basic_addr got %h exp 00003000", addr); end
        n_chk++; if (pcstall !== 1'b1) begin n_fail++; $display("FAIL basic_req_pcstall got %b exp 1", pcstall); end
        nx();
        gnt = 0; rvalid = 1; rdata = 32'h2402_0001;
        smp();
        n_chk++; if (vld !== 1'b1) begin n_fail++; $display("FAIL basic_vld got %b exp 1", vld); end
        n_chk++; if (instr !== 32'h2402_0001) begin n_fail++; $display("FAIL basic_instr got %h exp 24020001", instr); end
        n_chk++; if (pcstall !== 1'b0) begin n_fail++; $display("FAIL basic_pcstall got %b exp 0", pcstall); end
        n_chk++; if (npc !== 32'h0000_3004) begin n_fail++; $display("FAIL basic_npc got %h exp 00003004", npc); end
        nx();
        rvalid = 0;
    endtask

    task automatic test_stall_hold();
        pc = 32'h0000_3004; gnt = 1;
        smp();
        n_chk++; if (addr !== 32'h0000_3004) begin n_fail++; $display("FAIL hold_addr got %h exp 00003004", addr); end
        nx();
        gnt = 0; rvalid = 1; rdata = 32'h8C43_0010; stall = 1;
        smp();
        n_chk++; if (pcstall !== 1'b1) begin n_fail++; $display("FAIL hold_cap_pcstall got %b exp 1", pcstall); end
        n_chk++; if (vld !== 1'b0) begin n_fail++; $display("FAIL hold_cap_vld got %b exp 0", vld); end
        nx();
        rvalid = 0; rdata = 32'h0;
        for (int i = 0; i < 3; i++) begin
            smp();
            n_chk++; if (vld !== 1'b1) begin n_fail++; $display("FAIL hold_vld[%0d] got %b exp 1", i, vld); end
            n_chk++; if (instr !== 32'h8C43_0010) begin n_fail++; $display("FAIL hold_instr[%0d] got %h exp 8c430010", i, instr); end
            n_chk++; if (pcstall !== 1'b1) begin n_fail++; $display("FAIL hold_pcstall[%0d] got %b exp 1", i, pcstall); end
            nx();
        end
        stall = 0;
        smp();
        n_chk++; if (pcstall !== 1'b0) begin n_fail++; $display("FAIL hold_rel_pcstall got %b exp 0", pcstall); end
        n_chk++; if (npc !== 32'h0000_3008) begin n_fail++; $display("FAIL hold_rel_npc got %h exp 00003008", npc); end
        n_chk++; if (vld !== 1'b1) begin n_fail++; $display("FAIL hold_rel_vld got %b exp 1", vld); end
        nx();
        pc = 32'h0000_3008;
        smp();
        n_chk++; if (req !== 1'b1) begin n_fail++; $display("FAIL hold_next_req got %b exp 1", req); end
        n_chk++; if (vld !== 1'b0) begin n_fail++; $display("FAIL hold_next_vld got %b exp 0", vld); end
        n_chk++; if (pcstall !== 1'b1) begin n_fail++; $display("FAIL hold_next_pcstall got %b exp 1", pcstall); end
        nx();
    endtask

    task automatic test_redirect_wait();
        gnt = 1;
        nx();
        gnt = 0; redir = 1; tgt = 32'h0000_3102;
        smp();
        n_chk++; if (npc !== 32'h0000_3100) begin n_fail++; $display("FAIL rw_npc got %h exp 00003100", npc); end
        n_chk++; if (pcstall !== 1'b0) begin n_fail++; $display("FAIL rw_pcstall got %b exp 0", pcstall); end
        nx();
        redir = 0; pc = 32'h0000_3100; rvalid = 1; rdata = 32'hDEAD_BEEF;
        smp();
        n_chk++; if (vld !== 1'b0) begin n_fail++; $display("FAIL rw_kill_vld got %b exp 0", vld); end
        n_chk++; if (pcstall !== 1'b1) begin n_fail++; $display("FAIL rw_kill_pcstall got %b exp 1", pcstall); end
        nx();
        rvalid = 0;
        smp();
        n_chk++; if (req !== 1'b1) begin n_fail++; $display("FAIL rw_req got %b exp 1", req); end
        n_chk++; if (addr !== 32'h0000_3100) begin n_fail++; $display("FAIL rw_addr got %h exp 00003100", addr); end
        nx();
    endtask

    task automatic test_redirect_rvalid();
        gnt = 1;
        nx();
        gnt = 0; rvalid = 1; rdata = 32'h0BAD_0BAD; redir = 1; tgt = 32'h0000_3200;
        smp();
        n_chk++; if (npc !== 32'h0000_3200) begin n_fail++; $display("FAIL rr_npc got %h exp 00003200", npc); end
        n_chk++; if (pcstall !== 1'b0) begin n_fail++; $display("FAIL rr_pcstall got %b exp 0", pcstall); end
        n_chk++; if (vld !== 1'b0) begin n_fail++; $display("FAIL rr_vld got %b exp 0", vld); end
        nx();
        rvalid = 0; redir = 0; pc = 32'h0000_3200; gnt = 1;
        smp();
        n_chk++; if (req !== 1'b1) begin n_fail++; $display("FAIL rr_req got %b exp 1", req); end
        nx();
        gnt = 0; rvalid = 1; rdata = 32'h1111_2222;
        smp();
        n_chk++; if (vld !== 1'b1) begin n_fail++; $display("FAIL rr_next_vld got %b exp 1", vld); end
        n_chk++; if (instr !== 32'h1111_2222) begin n_fail++; $display("FAIL rr_next_instr got %h exp 11112222", instr); end
        n_chk++; if (npc !== 32'h0000_3204) begin n_fail++; $display("FAIL rr_next_npc got %h exp 00003204", npc); end
        nx();
        rvalid = 0;
    endtask

    task automatic test_wrap();
        pc = 32'hFFFF_FFFC; gnt = 1;
        nx();
        gnt = 0; rvalid = 1; rdata = 32'hAAAA_5555;
        smp();
        n_chk++; if (vld !== 1'b1) begin n_fail++; $display("FAIL wrap_vld got %b exp 1", vld); end
        n_chk++; if (npc !== 32'h0000_0000) begin n_fail++; $display("FAIL wrap_npc got %h exp 00000000", npc); end
        n_chk++; if (pcstall !== 1'b0) begin n_fail++; $display("FAIL wrap_pcstall got %b exp 0", pcstall); end
        nx();
        rvalid = 0;
    endtask

    task automatic test_timeout_reset();
        pc = 32'h0000_0000; gnt = 1;
        nx();
        gnt = 0;
        for (int i = 1; i <= 16; i++) begin
            smp();
            if (i == 16) begin
                n_chk++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL tmo_early got %b exp 0", tmo); end
            end
            nx();
        end
        smp();
        n_chk++; if (tmo !== 1'b1) begin n_fail++; $display("FAIL tmo_set got %b exp 1", tmo); end
        nx();
        rvalid = 1; rdata = 32'h0000_0001;
        smp();
        n_chk++; if (vld !== 1'b1) begin n_fail++; $display("FAIL tmo_late_vld got %b exp 1", vld); end
        nx();
        rvalid = 0;
        smp();
        n_chk++; if (tmo !== 1'b1) begin n_fail++; $display("FAIL tmo_sticky got %b exp 1", tmo); end
        nx();
        pc = 32'h0000_0004; gnt = 1;
        nx();
        gnt = 0; rvalid = 1; rdata = 32'h1234_5678;
        #1;
        n_chk++; if (vld !== 1'b1) begin n_fail++; $display("FAIL arst_pre_vld got %b exp 1", vld); end
        rst_n = 1'b0;
        #1;
        n_chk++; if (vld !== 1'b0) begin n_fail++; $display("FAIL arst_vld got %b exp 0", vld); end
        n_chk++; if (instr !== 32'h0) begin n_fail++; $display("FAIL arst_instr got %h exp 0", instr); end
        n_chk++; if (pcstall !== 1'b1) begin n_fail++; $display("FAIL arst_pcstall got %b exp 1", pcstall); end
        n_chk++; if (npc !== 32'h0000_3000) begin n_fail++; $display("FAIL arst_npc got %h exp 00003000", npc); end
        n_chk++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL arst_tmo got %b exp 0", tmo); end
        n_chk++; if (req !== 1'b0) begin n_fail++; $display("FAIL arst_req got %b exp 0", req); end
        nx(); nx();
        rst_n = 1'b1;
        smp();
        n_chk++; if (vld !== 1'b0) begin n_fail++; $display("FAIL idle_rvalid_vld got %b exp 0", vld); end
        nx();
        rvalid = 0; pc = 32'h0000_3000;
        smp();
        n_chk++; if (req !== 1'b1) begin n_fail++; $display("FAIL post_rst_req got %b exp 1", req); end
        n_chk++; if (vld !== 1'b0) begin n_fail++; $display("FAIL post_rst_vld got %b exp 0", vld); end
        nx();
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_stall_hold();
        test_redirect_wait();
        test_redirect_rvalid();
        test_wrap();
        test_timeout_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
